// File: rtl/hdmi_tx_stage_pkg.sv
// Shared types and constants for the median-filter video pipeline (RX window buffer and TX stage).
package hdmi_tx_stage_pkg;

  localparam int unsigned KERNEL_DIM = 5;
  localparam int unsigned BORDER     = KERNEL_DIM / 2;
  localparam int unsigned CHAN_W     = 8;
  localparam int unsigned PIXEL_W    = 3 * CHAN_W;

  // One RGB pixel, red in the top byte
  typedef struct packed {
    logic [CHAN_W-1:0] red;
    logic [CHAN_W-1:0] green;
    logic [CHAN_W-1:0] blue;
  } rgb_t;

  // Sync plus pixel word: dv at bit 26, hs at 25, vs at 24, RGB in 23:0
  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
    rgb_t rgb;
  } video_word_t;

  localparam int unsigned VIDEO_W = $bits(video_word_t);

  // Word carried through the TX latency-matching delay line
  typedef struct packed {
    logic        border;
    video_word_t vid;
  } tx_dly_word_t;

  localparam int unsigned TX_DLY_W = $bits(tx_dly_word_t);

  // Assemble a sync/pixel word from discrete signals
  function automatic video_word_t pack_video(input logic dv, input logic hs, input logic vs,
                                             input logic [CHAN_W-1:0] red,
                                             input logic [CHAN_W-1:0] green,
                                             input logic [CHAN_W-1:0] blue);
    video_word_t w;
    w.dv        = dv;
    w.hs        = hs;
    w.vs        = vs;
    w.rgb.red   = red;
    w.rgb.green = green;
    w.rgb.blue  = blue;
    return w;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register used to match a pipeline latency; DEPTH >= 1.
module video_delay_line #(
  parameter int unsigned DATA_W = 28,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_pipe [DEPTH];

  // Shift one stage per clock; stage 0 takes the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '{default: '0};
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/hdmi_tx_stage.sv
// Output end of the median pipeline: measures frame geometry, flags the incomplete-window
// border, delays sync/centre to line up with the median result and registers the TX stream.
module hdmi_tx_stage
  import hdmi_tx_stage_pkg::*;
#(
  parameter int unsigned FILT_LAT = 8,
  parameter int unsigned BORDER   = hdmi_tx_stage_pkg::BORDER,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_dv,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [7:0]       center_red,
  input  logic [7:0]       center_green,
  input  logic [7:0]       center_blue,
  input  logic [7:0]       filt_red,
  input  logic [7:0]       filt_green,
  input  logic [7:0]       filt_blue,
  input  logic             border_mode,
  output logic [7:0]       tx_red,
  output logic [7:0]       tx_green,
  output logic [7:0]       tx_blue,
  output logic             tx_dv,
  output logic             tx_hs,
  output logic             tx_vs,
  output logic [CNT_W-1:0] line_width,
  output logic [CNT_W-1:0] frame_height
);

  localparam int unsigned      EXT_W      = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BORDER_CNT = CNT_W'(BORDER);
  localparam logic [EXT_W-1:0] BORDER_EXT = EXT_W'(BORDER);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_dv_prev;
  logic             r_vs_prev;

  logic             w_dv_fall;
  logic             w_vs_rise;
  logic [EXT_W-1:0] w_x_ext;
  logic [EXT_W-1:0] w_y_ext;
  logic             w_border;
  tx_dly_word_t     w_dly_in;
  tx_dly_word_t     w_dly_out;
  rgb_t             w_pix;

  assign w_dv_fall = r_dv_prev & ~in_dv;
  assign w_vs_rise = ~r_vs_prev & in_vs;

  // Pixel/line counters and last measured line width / frame height
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_dv_prev    <= 1'b0;
      r_vs_prev    <= 1'b0;
      line_width   <= '0;
      frame_height <= '0;
    end else begin
      r_dv_prev <= in_dv;
      r_vs_prev <= in_vs;
      // r_x holds the number of pixels already seen, so at the falling edge it is the width
      if (in_dv) begin
        r_x <= (r_x == CNT_MAX) ? r_x : r_x + CNT_ONE;
      end else if (w_dv_fall) begin
        line_width <= r_x;
        r_x        <= '0;
      end
      if (w_vs_rise) begin
        frame_height <= r_y;
        r_y          <= '0;
      end else if (w_dv_fall) begin
        r_y <= (r_y == CNT_MAX) ? r_y : r_y + CNT_ONE;
      end
    end
  end

  // Right/bottom tests are done as x + BORDER >= size so tiny sizes cannot underflow;
  // this also makes every pixel border when the size is below 2*BORDER+1.
  assign w_x_ext  = {1'b0, r_x} + BORDER_EXT;
  assign w_y_ext  = {1'b0, r_y} + BORDER_EXT;
  assign w_border = (r_x < BORDER_CNT) || (r_y < BORDER_CNT) ||
                    ((line_width   != '0) && (w_x_ext >= {1'b0, line_width})) ||
                    ((frame_height != '0) && (w_y_ext >= {1'b0, frame_height}));

  // Pack sync, border flag and centre pixel for the delay line
  always_comb begin
    w_dly_in        = '0;
    w_dly_in.border = w_border;
    w_dly_in.vid    = pack_video(in_dv, in_hs, in_vs, center_red, center_green, center_blue);
  end

  video_delay_line #(
    .DATA_W (TX_DLY_W),
    .DEPTH  (FILT_LAT)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst),
    .i_data (w_dly_in),
    .o_data (w_dly_out)
  );

  // Choose between blank, border replacement and filtered pixel
  always_comb begin
    w_pix = '0;
    if (w_dly_out.vid.dv) begin
      if (w_dly_out.border) begin
        if (border_mode) begin
          w_pix = w_dly_out.vid.rgb;
        end
      end else begin
        w_pix = rgb_t'({filt_red, filt_green, filt_blue});
      end
    end
  end

  // Registered TX stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_red   <= '0;
      tx_green <= '0;
      tx_blue  <= '0;
      tx_dv    <= 1'b0;
      tx_hs    <= 1'b0;
      tx_vs    <= 1'b0;
    end else begin
      tx_red   <= w_pix.red;
      tx_green <= w_pix.green;
      tx_blue  <= w_pix.blue;
      tx_dv    <= w_dly_out.vid.dv;
      tx_hs    <= w_dly_out.vid.hs;
      tx_vs    <= w_dly_out.vid.vs;
    end
  end

endmodule
